// File: rtl/decode_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Imported by decode_scoreboard and wb_port_reservation.
package decode_scoreboard_pkg;

    localparam int unsigned SB_LAT_ALU     = 0;
    localparam int unsigned SB_LAT_LOAD    = 1;
    localparam int unsigned SB_WB_DIST_ALU = 2;
    localparam int unsigned SB_CNT_W       = 3;

    typedef enum logic [1:0] {
        LAT_ALU  = 2'd0,
        LAT_LOAD = 2'd1,
        LAT_MUL  = 2'd2,
        LAT_RSVD = 2'd3
    } lat_class_t;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_FLUSH = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic                pending;
        logic [SB_CNT_W-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/decode_scoreboard_wb_port_reservation.sv
// RF write-port reservation: one bit per future WB slot, shifted toward WB every unfrozen cycle.
// conflict reports the slot a new issue would claim, i.e. the target bit after this cycle's shift.
module wb_port_reservation
    import decode_scoreboard_pkg::*;
#(
    parameter int unsigned DEPTH  = 7,
    parameter int unsigned DIST_W = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              freeze,
    input  logic              clear,
    input  logic [DIST_W-1:0] check_dist,
    output logic              conflict,
    input  logic              reserve,
    input  logic [DIST_W-1:0] reserve_dist
);

    logic [DEPTH-1:0] vec_q;
    logic [DEPTH-1:0] shifted;
    logic [DEPTH-1:0] claim;

    assign shifted  = vec_q >> 1;
    assign conflict = shifted[check_dist];
    assign claim    = reserve ? (DEPTH'(1) << reserve_dist) : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vec_q <= '0;
        end else if (clear) begin
            vec_q <= '0;
        end else if (!freeze) begin
            vec_q <= shifted | claim;
        end
    end

endmodule

// File: rtl/decode_scoreboard.sv
// Decode hazard scheduler: RAW holds, WB write-port conflicts and WB flush sequencing.
// Define SCOREBOARD_STATS_EN to add saturating RAW / port-conflict stall counters.
module decode_scoreboard
    import decode_scoreboard_pkg::*;
#(
    parameter int unsigned NUM_REGS   = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MUL_LAT    = 5,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dec_valid,
    input  logic [REG_ADDR_W-1:0] dec_src1_addr,
    input  logic                  dec_src1_used,
    input  logic [REG_ADDR_W-1:0] dec_src2_addr,
    input  logic                  dec_src2_used,
    input  logic [REG_ADDR_W-1:0] dec_dst_addr,
    input  logic                  dec_dst_we,
    input  logic [1:0]            dec_lat_class,
    input  logic                  cache_stall,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic                  xcpt_flush,
    output logic                  stall_decode,
    output logic                  flush_decode,
    output logic                  issue_fire
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]           stat_raw_stalls,
    output logic [31:0]           stat_port_stalls
`endif
);

    localparam int unsigned RSV_DEPTH = MUL_LAT + 2;
    localparam int unsigned DIST_W    = $clog2(RSV_DEPTH);

    sb_state_t         state_q, state_d;
    logic [NUM_REGS-1:0] pending_q;
    logic [CNT_W-1:0]  cnt_q [NUM_REGS];
    lat_class_t        lat_class;
    logic [CNT_W-1:0]  issue_cnt;
    logic [DIST_W-1:0] wb_dist;
    logic              raw_hit, rsv_conflict, port_hit, record;

    assign lat_class = lat_class_t'(dec_lat_class);

    always_comb begin
        issue_cnt = CNT_W'(SB_LAT_ALU);
        wb_dist   = DIST_W'(SB_WB_DIST_ALU);
        case (lat_class)
            LAT_LOAD: issue_cnt = CNT_W'(SB_LAT_LOAD);
            LAT_MUL: begin
                issue_cnt = CNT_W'(MUL_LAT - 1);
                wb_dist   = DIST_W'(MUL_LAT + 1);
            end
            default: ;
        endcase
    end

    // A producer whose count reached 0 is covered by a bypass path, so only nonzero counts hold.
    assign raw_hit = (dec_src1_used && pending_q[dec_src1_addr] && (cnt_q[dec_src1_addr] != '0))
                  || (dec_src2_used && pending_q[dec_src2_addr] && (cnt_q[dec_src2_addr] != '0));

    wb_port_reservation #(
        .DEPTH (RSV_DEPTH),
        .DIST_W(DIST_W)
    ) u_wb_port_reservation (
        .clock       (clock),
        .reset       (reset),
        .freeze      (cache_stall),
        .clear       (xcpt_flush),
        .check_dist  (wb_dist),
        .conflict    (rsv_conflict),
        .reserve     (record),
        .reserve_dist(wb_dist)
    );

    assign port_hit = dec_dst_we && rsv_conflict;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= SB_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        stall_decode = 1'b0;
        case (state_q)
            SB_RUN: begin
                stall_decode = dec_valid && (raw_hit || port_hit || cache_stall);
                if (xcpt_flush) state_d = SB_FLUSH;
            end
            SB_FLUSH: begin
                stall_decode = 1'b1;
                state_d      = xcpt_flush ? SB_FLUSH : SB_RUN;
            end
            default: state_d = SB_RUN;
        endcase
    end

    assign flush_decode = (state_q == SB_FLUSH);
    assign issue_fire   = dec_valid && !stall_decode && !flush_decode;
    assign record       = issue_fire && dec_dst_we;

    // Later assignments in the loop body win: a same-cycle issue overrides the WB clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else if (xcpt_flush) begin
            pending_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (!cache_stall && (cnt_q[i] != '0)) cnt_q[i] <= cnt_q[i] - 1'b1;
                if (wb_valid && (wb_addr == REG_ADDR_W'(i))) pending_q[i] <= 1'b0;
                if (record && (dec_dst_addr == REG_ADDR_W'(i)) && (i != 0)) begin
                    pending_q[i] <= 1'b1;
                    cnt_q[i]     <= issue_cnt;
                end
            end
        end
    end

`ifdef SCOREBOARD_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_raw_stalls  <= '0;
            stat_port_stalls <= '0;
        end else if ((state_q == SB_RUN) && dec_valid) begin
            if (raw_hit) begin
                if (stat_raw_stalls != '1) stat_raw_stalls <= stat_raw_stalls + 32'd1;
            end else if (port_hit) begin
                if (stat_port_stalls != '1) stat_port_stalls <= stat_port_stalls + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: tick-based reference model checked every cycle,
// plus directed instruction sequences with hand-computed stall counts.
module tb_decode_scoreboard;

    localparam int unsigned MUL_LAT = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dec_valid = 1'b0;
    logic [4:0] dec_src1_addr = '0;
    logic       dec_src1_used = 1'b0;
    logic [4:0] dec_src2_addr = '0;
    logic       dec_src2_used = 1'b0;
    logic [4:0] dec_dst_addr = '0;
    logic       dec_dst_we = 1'b0;
    logic [1:0] dec_lat_class = '0;
    logic       cache_stall = 1'b0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_addr = '0;
    logic       xcpt_flush = 1'b0;
    logic       stall_decode, flush_decode, issue_fire;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stat_raw_stalls, stat_port_stalls;
`endif

    always #5 clock = ~clock;

    decode_scoreboard #(
        .NUM_REGS  (32),
        .REG_ADDR_W(5),
        .MUL_LAT   (MUL_LAT),
        .CNT_W     (3)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .dec_valid    (dec_valid),
        .dec_src1_addr(dec_src1_addr),
        .dec_src1_used(dec_src1_used),
        .dec_src2_addr(dec_src2_addr),
        .dec_src2_used(dec_src2_used),
        .dec_dst_addr (dec_dst_addr),
        .dec_dst_we   (dec_dst_we),
        .dec_lat_class(dec_lat_class),
        .cache_stall  (cache_stall),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .xcpt_flush   (xcpt_flush),
        .stall_decode (stall_decode),
        .flush_decode (flush_decode),
        .issue_fire   (issue_fire)
`ifdef SCOREBOARD_STATS_EN
        ,
        .stat_raw_stalls (stat_raw_stalls),
        .stat_port_stalls(stat_port_stalls)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: time is counted in unfrozen ticks; a producer is ready at an absolute
    // tick, and each writer owns an absolute WB tick.
    int unsigned tick = 0;
    bit          m_pend [32];
    int unsigned m_ready[32];
    bit          m_slot [int unsigned];
    bit          m_flush = 0;

    function automatic int unsigned lat_of(input logic [1:0] c);
        return (c == 2'd1) ? 1 : (c == 2'd2) ? MUL_LAT - 1 : 0;
    endfunction

    function automatic int unsigned dist_of(input logic [1:0] c);
        return (c == 2'd2) ? MUL_LAT + 1 : 2;
    endfunction

    function automatic bit busy(input logic [4:0] a);
        return m_pend[a] && (tick < m_ready[a]);
    endfunction

    function automatic bit m_stall();
        bit raw, port;
        raw  = (dec_src1_used && busy(dec_src1_addr)) || (dec_src2_used && busy(dec_src2_addr));
        port = dec_dst_we && m_slot.exists(tick + dist_of(dec_lat_class));
        return m_flush || (dec_valid && (raw || port || cache_stall));
    endfunction

    function automatic bit m_issue();
        return dec_valid && !m_stall() && !m_flush;
    endfunction

    always @(posedge clock or negedge reset) begin : model
        bit iss;
        if (!reset) begin
            m_pend = '{default: 0};
            m_slot.delete();
            m_flush = 0;
            tick = 0;
        end else begin
            iss = m_issue();
            if (xcpt_flush) begin
                m_pend = '{default: 0};
                m_slot.delete();
                m_flush = 1;
            end else begin
                m_flush = 0;
                if (wb_valid) m_pend[wb_addr] = 0;
                if (iss && dec_dst_we) begin
                    if (dec_dst_addr != 0) begin
                        m_pend[dec_dst_addr]  = 1;
                        m_ready[dec_dst_addr] = tick + 1 + lat_of(dec_lat_class);
                    end
                    m_slot[tick + dist_of(dec_lat_class)] = 1;
                end
                if (!cache_stall) tick++;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("cyc_stall_decode", int'(stall_decode), int'(m_stall()));
            chk("cyc_flush_decode", int'(flush_decode), int'(m_flush));
            chk("cyc_issue_fire",   int'(issue_fire),   int'(m_issue()));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        dec_valid = 0; dec_src1_used = 0; dec_src2_used = 0; dec_dst_we = 0;
        dec_src1_addr = '0; dec_src2_addr = '0; dec_dst_addr = '0; dec_lat_class = '0;
    endtask

    // Presents one instruction until it issues; negative register means "not used / no write".
    task automatic send(input string name, input int cls, input int dst, input int s1,
                        input int s2, input int exp_stalls);
        int stalls;
        bit done;
        stalls = 0;
        done   = 0;
        dec_valid     = 1;
        dec_lat_class = 2'(cls);
        dec_dst_we    = (dst >= 0);
        dec_dst_addr  = 5'((dst >= 0) ? dst : 0);
        dec_src1_used = (s1 >= 0);
        dec_src1_addr = 5'((s1 >= 0) ? s1 : 0);
        dec_src2_used = (s2 >= 0);
        dec_src2_addr = 5'((s2 >= 0) ? s2 : 0);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clock);
            if (issue_fire) done = 1;
            else stalls++;
            step();
        end
        clear_inputs();
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: no issue within 40 cycles, required issue", name);
        end else begin
            chk(name, stalls, exp_stalls);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 0;
        chk_en = 1;
        @(negedge clock);
        chk("rst_stall", int'(stall_decode), 0);
        chk("rst_flush", int'(flush_decode), 0);
        chk("rst_issue", int'(issue_fire), 0);
        step();
        reset = 1;
        repeat (2) step();

        // cls: 0 ALU, 1 LOAD, 2 MUL, 3 reserved
        send("alu_b2b_1", 0, 3, 1, 2, 0);
        send("alu_b2b_2", 0, 4, 3, -1, 0);
        repeat (8) step();

        send("ld", 1, 5, -1, -1, 0);
        send("ld_use", 0, 6, 5, -1, 1);
        repeat (8) step();

        send("mul", 2, 7, -1, -1, 0);
        send("mul_use", 0, 8, 7, -1, 4);
        repeat (8) step();

        send("port_mul", 2, 9, -1, -1, 0);
        send("port_alu1", 0, 10, -1, -1, 0);
        send("port_alu2", 0, 11, -1, -1, 0);
        send("port_alu3", 0, 12, -1, -1, 0);
        send("port_alu4", 0, 13, -1, -1, 1);
        repeat (8) step();

        send("frz_mul", 2, 14, -1, -1, 0);
        fork
            send("frz_use", 0, 15, 14, -1, 7);
            begin
                step();
                cache_stall = 1;
                repeat (3) @(posedge clock);
                #1 cache_stall = 0;
            end
        join
        repeat (8) step();

        send("r0_ld", 1, 0, -1, -1, 0);
        send("r0_use", 0, 1, 0, -1, 0);
        send("rsvd_cls", 3, 26, -1, -1, 0);
        send("rsvd_use", 0, 27, 26, -1, 0);
        repeat (8) step();

        send("wb_mul", 2, 22, -1, -1, 0);
        wb_valid = 1; wb_addr = 5'd22;
        step();
        wb_valid = 0;
        send("wb_cleared_use", 0, 23, 22, -1, 0);
        wb_valid = 1; wb_addr = 5'd24;
        send("setwin_mul", 2, 24, -1, -1, 0);
        wb_valid = 0;
        send("setwin_use", 0, 25, 24, -1, 4);
        repeat (8) step();

        send("fl_ld1", 1, 16, -1, -1, 0);
        send("fl_mul", 2, 17, -1, -1, 0);
        send("fl_ld2", 1, 18, -1, -1, 0);
        xcpt_flush = 1;
        step();
        xcpt_flush = 0;
        @(negedge clock);
        chk("flush_pulse", int'(flush_decode), 1);
        chk("flush_stall", int'(stall_decode), 1);
        step();
        send("flush_use", 0, 19, 17, 18, 0);
        repeat (8) step();

        send("ar_mul", 2, 20, -1, -1, 0);
        dec_valid = 1; dec_src1_used = 1; dec_src1_addr = 5'd20;
        dec_dst_we = 1; dec_dst_addr = 5'd21;
        @(negedge clock);
        chk("ar_pre_stall", int'(stall_decode), 1);
        #2 reset = 0;
        #1;
        chk("ar_stall", int'(stall_decode), 0);
        chk("ar_flush", int'(flush_decode), 0);
        step();
        reset = 1;
        clear_inputs();
        send("ar_use", 0, 21, 20, -1, 0);
        repeat (4) step();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
